// File: rtl/vend_pkg.sv
// Shared coin encoding, coin values and dispenser FSM states for the vending
// machine's credit and payout sides.
package vend_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        NICKEL  = 2'b01,
        DIME    = 2'b10,
        QUARTER = 2'b11
    } coin_e;

    // Coin values in nickel units.
    localparam int unsigned VAL_NICKEL  = 1;
    localparam int unsigned VAL_DIME    = 2;
    localparam int unsigned VAL_QUARTER = 5;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SELECT,
        REQ,
        RELEASE,
        DONE
    } state_e;

endpackage

// File: rtl/vend_change_dispenser_if.sv
// Dispenser-side bundle: start/credit from the credit FSM, coin hopper
// handshake, and vend/status outputs.
interface vend_change_dispenser_if #(
    parameter int CREDIT_W = 4
);
    logic                start;
    logic [CREDIT_W-1:0] credit;
    logic [2:0]          hopper_empty;
    logic                coin_ack;
    logic                coin_req;
    logic [1:0]          coin_type;
    logic                vend;
    logic                busy;
    logic                done;
    logic                insufficient;
    logic                short_change;

    modport master (
        output start, credit, hopper_empty, coin_ack,
        input  coin_req, coin_type, vend, busy, done, insufficient, short_change
    );

    modport slave (
        input  start, credit, hopper_empty, coin_ack,
        output coin_req, coin_type, vend, busy, done, insufficient, short_change
    );
endinterface

// File: rtl/vend_change_dispenser_coin_select.sv
// Largest-fit coin picker: quarter, then dime, then nickel, skipping any coin
// whose hopper is empty or whose value exceeds what is still owed.
module coin_select
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 4
) (
    input  logic [CREDIT_W-1:0] remain_i,
    input  logic [2:0]          hopper_empty_i,
    output coin_e               coin_o,
    output logic [CREDIT_W-1:0] value_o
);
    localparam logic [CREDIT_W-1:0] V_Q = CREDIT_W'(VAL_QUARTER);
    localparam logic [CREDIT_W-1:0] V_D = CREDIT_W'(VAL_DIME);
    localparam logic [CREDIT_W-1:0] V_N = CREDIT_W'(VAL_NICKEL);

    always_comb begin
        coin_o  = NONE;
        value_o = '0;
        if (!hopper_empty_i[2] && remain_i >= V_Q) begin
            coin_o  = QUARTER;
            value_o = V_Q;
        end else if (!hopper_empty_i[1] && remain_i >= V_D) begin
            coin_o  = DIME;
            value_o = V_D;
        end else if (!hopper_empty_i[0] && remain_i >= V_N) begin
            coin_o  = NICKEL;
            value_o = V_N;
        end
    end
endmodule

// File: rtl/vend_change_dispenser.sv
// Vend/payout controller: checks latched credit against the price, pulses vend,
// then pays change or a full refund one coin at a time over a four-phase hopper handshake.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 4,
    parameter int PRICE    = 5
) (
    input logic                    clk,
    input logic                    reset_n,
    vend_change_dispenser_if.slave bus
);
    localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] remain_q, remain_d;
    logic [CREDIT_W-1:0] val_q, val_d;
    coin_e               coin_q, coin_d;
    logic                vend_q, vend_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                req_q, req_d;
    logic                insuf_q, insuf_d;
    logic                short_q, short_d;

    coin_e               sel_coin;
    logic [CREDIT_W-1:0] sel_val;

    coin_select #(.CREDIT_W(CREDIT_W)) u_coin_select (
        .remain_i       (remain_q),
        .hopper_empty_i (bus.hopper_empty),
        .coin_o         (sel_coin),
        .value_o        (sel_val)
    );

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        val_d    = val_q;
        coin_d   = coin_q;
        insuf_d  = insuf_q;
        short_d  = short_q;
        vend_d   = 1'b0;
        unique case (state_q)
            IDLE: if (bus.start) begin
                remain_d = bus.credit;
                insuf_d  = 1'b0;
                short_d  = 1'b0;
                // vend is registered, so decide it here to have it high during CHECK
                vend_d   = (bus.credit >= PRICE_W);
                state_d  = CHECK;
            end
            CHECK: begin
                if (remain_q >= PRICE_W) remain_d = remain_q - PRICE_W;
                else                     insuf_d  = 1'b1;
                state_d = SELECT;
            end
            SELECT: begin
                if (remain_q == '0) begin
                    state_d = DONE;
                end else if (sel_coin != NONE) begin
                    coin_d  = sel_coin;
                    val_d   = sel_val;
                    state_d = REQ;
                end else begin
                    short_d = 1'b1;
                    state_d = DONE;
                end
            end
            REQ: if (bus.coin_ack) begin
                remain_d = remain_q - val_q;
                coin_d   = NONE;
                state_d  = RELEASE;
            end
            RELEASE: if (!bus.coin_ack) state_d = SELECT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
        req_d  = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            remain_q <= '0;
            val_q    <= '0;
            coin_q   <= NONE;
            vend_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            req_q    <= 1'b0;
            insuf_q  <= 1'b0;
            short_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            val_q    <= val_d;
            coin_q   <= coin_d;
            vend_q   <= vend_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            req_q    <= req_d;
            insuf_q  <= insuf_d;
            short_q  <= short_d;
        end
    end

    assign bus.coin_req     = req_q;
    assign bus.coin_type    = coin_q;
    assign bus.vend         = vend_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.insufficient = insuf_q;
    assign bus.short_change = short_q;
endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed bench for vend_change_dispenser: a responsive hopper model acks each
// coin request; coin sequence, pulse timing and sticky flags are checked.
module tb_vend_change_dispenser;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    vend_change_dispenser_if #(.CREDIT_W(4)) bus ();

    vend_change_dispenser #(.CREDIT_W(4), .PRICE(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One transaction. Cycle k=1 is the cycle after start is sampled.
    // inj_k > 0 drives a stray start (credit 15) in that cycle.
    task automatic txn(input string nm, input logic [3:0] cr, input logic [2:0] he,
                       input bit e_vend, input bit e_ins, input bit e_sht,
                       input int e_done, input int inj_k);
        int vend_n = 0, vend_k = 0, done_k = 0, req_k = 0;
        got_q.delete();
        @(negedge clk);
        bus.start = 1'b1; bus.credit = cr; bus.hopper_empty = he;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            bus.start  = (k == inj_k);
            bus.credit = (k == inj_k) ? 4'd15 : cr;
            if (k == 1) chk({nm, " busy@1"}, 32'(bus.busy), 1);
            if (bus.vend) begin vend_n++; vend_k = k; end
            if (bus.coin_req && !bus.coin_ack) begin
                if (req_k == 0) req_k = k;
                got_q.push_back(bus.coin_type);
                bus.coin_ack = 1'b1;
            end else if (!bus.coin_req && bus.coin_ack) begin
                bus.coin_ack = 1'b0;
            end
            if (bus.done) begin done_k = k; break; end
        end
        chk({nm, " done_seen"}, 32'(done_k != 0), 1);
        chk({nm, " vend_cnt"}, 32'(vend_n), 32'(e_vend));
        if (e_vend) chk({nm, " vend_cyc"}, 32'(vend_k), 1);
        if (e_done > 0) chk({nm, " done_cyc"}, 32'(done_k), 32'(e_done));
        if (exp_q.size() > 0) chk({nm, " first_req_cyc"}, 32'(req_k), 3);
        chk({nm, " coin_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s coin%0d", nm, i), 32'(got_q[i]), 32'(exp_q[i]));
        chk({nm, " insufficient"}, 32'(bus.insufficient), 32'(e_ins));
        chk({nm, " short_change"}, 32'(bus.short_change), 32'(e_sht));
        @(negedge clk);
        chk({nm, " busy_after"}, 32'(bus.busy), 0);
        chk({nm, " done_1cyc"}, 32'(bus.done), 0);
        chk({nm, " ins_sticky"}, 32'(bus.insufficient), 32'(e_ins));
        chk({nm, " sht_sticky"}, 32'(bus.short_change), 32'(e_sht));
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " coin_req"}, 32'(bus.coin_req), 0);
        chk({nm, " coin_type"}, 32'(bus.coin_type), 0);
        chk({nm, " vend"}, 32'(bus.vend), 0);
        chk({nm, " busy"}, 32'(bus.busy), 0);
        chk({nm, " done"}, 32'(bus.done), 0);
        chk({nm, " flags"}, 32'({bus.insufficient, bus.short_change}), 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.credit = '0; bus.hopper_empty = '0; bus.coin_ack = 1'b0;
        #23;
        chk_idle("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        exp_q = {};                          txn("exact5",  4'd5,  3'b000, 1, 0, 0, 3, 0);
        exp_q = {2'b11, 2'b10};              txn("chg12",   4'd12, 3'b000, 1, 0, 0, 9, 0);
        exp_q = {2'b10, 2'b01};              txn("refund3", 4'd3,  3'b000, 0, 1, 0, 0, 0);
        exp_q = {2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
                                             txn("qempty",  4'd15, 3'b100, 1, 0, 0, 0, 0);
        exp_q = {};                          txn("short6",  4'd6,  3'b001, 1, 0, 1, 3, 0);
        // Flags from the prior short-change run clear on the next accepted start.
        exp_q = {2'b01};                     txn("chg6",    4'd6,  3'b000, 1, 0, 0, 0, 0);

        // Reset asserted mid-handshake: coin_req must drop without a clock edge.
        @(negedge clk);
        bus.start = 1'b1; bus.credit = 4'd12; bus.hopper_empty = 3'b000;
        @(negedge clk);
        bus.start = 1'b0;
        begin
            int waited = 0;
            while (!bus.coin_req && waited < 20) begin @(negedge clk); waited++; end
            chk("rst_mid reached_req", 32'(bus.coin_req), 1);
        end
        #2 reset_n = 1'b0;
        #1 chk_idle("rst_mid");
        bus.coin_ack = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_idle("post_rst");

        // Stray start while busy must not disturb the transaction in flight.
        exp_q = {2'b11, 2'b10};              txn("busy_start", 4'd12, 3'b000, 1, 0, 0, 9, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
